scandoubler_timing: RTL and testbench

SCANDOUBLER_TIMING -- requirements
Module: scandoubler_timing

---
 rtl/scandoubler_pkg.sv | 7 +
 rtl/scandoubler_hsgen.sv | 35 +++
 rtl/scandoubler_timing.sv | 98 +++++++++
 tb/tb_scandoubler_timing.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// Shared scandoubler parameters: default counter widths used by every scandoubler stage.
package scandoubler_pkg;

  localparam int SD_HCNT_WIDTH  = 9;
  localparam int SD_HSCNT_WIDTH = 12;

endpackage

// File: rtl/scandoubler_hsgen.sv
// Doubled-hsync pulse generator: each output line start opens a pulse half as long as the input hsync.
module scandoubler_hsgen
  import scandoubler_pkg::*;
#(
  parameter int HSCNT_WIDTH = SD_HSCNT_WIDTH
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ols,
  input  logic [HSCNT_WIDTH-1:0] hs_len,
  output logic                   hs_sd
);

  localparam logic [HSCNT_WIDTH-1:0] HSCNT_ONE = HSCNT_WIDTH'(1);

  logic [HSCNT_WIDTH-1:0] hs_timer;

  // A new line start always reloads, so back-to-back starts keep hs_sd high without a gap.
  // The pulse ends on the edge the timer leaves 1 (or immediately when loaded with 0).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_sd    <= 1'b0;
      hs_timer <= '0;
    end else if (ols) begin
      hs_sd    <= 1'b1;
      hs_timer <= hs_len >> 1;
    end else if (hs_sd) begin
      if (hs_timer != '0)
        hs_timer <= hs_timer - HSCNT_ONE;
      if ((hs_timer >> 1) == '0)
        hs_sd <= 1'b0;
    end
  end

endmodule

// File: rtl/scandoubler_timing.sv
// Scandoubler timing: input/output line counters, buffer-half select, doubled hsync and retimed vsync.
module scandoubler_timing
  import scandoubler_pkg::*;
#(
  parameter int HCNT_WIDTH  = SD_HCNT_WIDTH,
  parameter int HSCNT_WIDTH = SD_HSCNT_WIDTH
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  pe_in,
  input  logic                  pe_out,
  input  logic                  hs_in,
  input  logic                  vs_in,
  output logic [HCNT_WIDTH-1:0] hcnt,
  output logic [HCNT_WIDTH-1:0] sd_hcnt,
  output logic                  line_toggle,
  output logic                  hs_sd,
  output logic                  vs_out
);

  localparam logic [HCNT_WIDTH-1:0]  HCNT_MAX  = '1;
  localparam logic [HCNT_WIDTH-1:0]  HCNT_ONE  = HCNT_WIDTH'(1);
  localparam logic [HSCNT_WIDTH-1:0] HSCNT_MAX = '1;
  localparam logic [HSCNT_WIDTH-1:0] HSCNT_ONE = HSCNT_WIDTH'(1);

  logic                   hs_pe;
  logic                   hs_d;
  logic [HCNT_WIDTH-1:0]  hs_max;
  logic [HSCNT_WIDTH-1:0] hs_cnt;
  logic [HSCNT_WIDTH-1:0] hs_len;
  logic                   ils;
  logic                   ols;

  // ILS wins any coincidence with the wrap compare simply by being OR-ed into one strobe.
  assign ils = pe_in & hs_in & ~hs_pe;
  assign ols = ils | (pe_out & (sd_hcnt == hs_max));

  // Input side: hs_max stays all-ones until the first measured line so sd_hcnt free-runs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_pe       <= 1'b0;
      hcnt        <= '0;
      hs_max      <= HCNT_MAX;
      line_toggle <= 1'b0;
    end else if (pe_in) begin
      hs_pe <= hs_in;
      if (ils) begin
        hs_max      <= hcnt;
        hcnt        <= '0;
        line_toggle <= ~line_toggle;
      end else if (hcnt != HCNT_MAX) begin
        hcnt <= hcnt + HCNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_hcnt <= '0;
      vs_out  <= 1'b0;
    end else begin
      if (ols)
        sd_hcnt <= '0;
      else if (pe_out)
        sd_hcnt <= sd_hcnt + HCNT_ONE;
      if (pe_out)
        vs_out <= vs_in;
    end
  end

  // Input hsync length in clk_sys cycles, captured on its falling edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_d   <= 1'b0;
      hs_cnt <= '0;
      hs_len <= '0;
    end else begin
      hs_d <= hs_in;
      if (~hs_in & hs_d) begin
        hs_len <= hs_cnt;
        hs_cnt <= '0;
      end else if (hs_in && hs_cnt != HSCNT_MAX) begin
        hs_cnt <= hs_cnt + HSCNT_ONE;
      end
    end
  end

  scandoubler_hsgen #(
    .HSCNT_WIDTH(HSCNT_WIDTH)
  ) u_hsgen (
    .clk_sys(clk_sys),
    .reset  (reset),
    .ols    (ols),
    .hs_len (hs_len),
    .hs_sd  (hs_sd)
  );

endmodule

// File: tb/tb_scandoubler_timing.sv
// Bench for scandoubler_timing: directed line scenarios plus random traffic against a behavioural model.
module tb_scandoubler_timing;

  localparam int HMAX  = 511;
  localparam int HSMAX = 4095;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       pe_in   = 1'b0;
  logic       pe_out  = 1'b0;
  logic       hs_in   = 1'b0;
  logic       vs_in   = 1'b0;
  logic [8:0] hcnt;
  logic [8:0] sd_hcnt;
  logic       line_toggle;
  logic       hs_sd;
  logic       vs_out;

  always #5 clk_sys = ~clk_sys;

  scandoubler_timing dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pe_in      (pe_in),
    .pe_out     (pe_out),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hcnt       (hcnt),
    .sd_hcnt    (sd_hcnt),
    .line_toggle(line_toggle),
    .hs_sd      (hs_sd),
    .vs_out     (vs_out)
  );

  // Behavioural model: the hsync pulse is tracked as "cycles still to stay high".
  int m_hcnt, m_sd, m_hsmax, m_hscnt, m_hslen, m_rem;
  bit m_hs_pe, m_hsd, m_tog, m_vs;

  always @(posedge clk_sys) begin : model_blk
    bit ils, ols;
    if (reset) begin
      m_hcnt = 0; m_sd = 0; m_hsmax = HMAX; m_hscnt = 0; m_hslen = 0; m_rem = 0;
      m_hs_pe = 0; m_hsd = 0; m_tog = 0; m_vs = 0;
    end else begin
      ils = pe_in && hs_in && !m_hs_pe;
      ols = ils || (pe_out && m_sd == m_hsmax);
      if (ols) m_rem = (m_hslen / 2 > 0) ? m_hslen / 2 : 1;
      else if (m_rem > 0) m_rem = m_rem - 1;
      if (ols) m_sd = 0;
      else if (pe_out) m_sd = (m_sd + 1) % (HMAX + 1);
      if (pe_out) m_vs = vs_in;
      if (pe_in) begin
        if (ils) begin
          m_hsmax = m_hcnt;
          m_hcnt  = 0;
          m_tog   = ~m_tog;
        end else if (m_hcnt < HMAX) begin
          m_hcnt = m_hcnt + 1;
        end
        m_hs_pe = hs_in;
      end
      if (!hs_in && m_hsd) begin
        m_hslen = m_hscnt;
        m_hscnt = 0;
      end else if (hs_in && m_hscnt < HSMAX) begin
        m_hscnt = m_hscnt + 1;
      end
      m_hsd = hs_in;
    end
  end

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  int   run_len = 0, last_w = 0, rises = 0, sd_peak = 0, tog_flips = 0;
  logic prev_sd = 1'b0, prev_tog = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare on the falling edge, gather pulse statistics, then drive the next inputs.
  task automatic step(input logic pi, input logic po, input logic hi, input logic vi, input logic rs);
    @(negedge clk_sys);
    if (chk_en) begin
      check("hcnt", 32'(hcnt), 32'(m_hcnt));
      check("sd_hcnt", 32'(sd_hcnt), 32'(m_sd));
      check("line_toggle", 32'(line_toggle), 32'(m_tog));
      check("hs_sd", 32'(hs_sd), 32'(m_rem > 0));
      check("vs_out", 32'(vs_out), 32'(m_vs));
    end
    if (hs_sd) run_len++;
    else if (run_len > 0) begin
      last_w  = run_len;
      run_len = 0;
    end
    if (hs_sd && !prev_sd) rises++;
    if (line_toggle != prev_tog) tog_flips++;
    prev_sd  = hs_sd;
    prev_tog = line_toggle;
    if (int'(sd_hcnt) > sd_peak) sd_peak = int'(sd_hcnt);
    pe_in  = pi;
    pe_out = po;
    hs_in  = hi;
    vs_in  = vi;
    reset  = rs;
  endtask

  // Regular line: pe_in every 4 clk, pe_out every 2 clk, 100 pe_in per line, hsync for 8 pe_in.
  task automatic steady(input int ncyc, input int rst_at);
    for (int i = 0; i < ncyc; i++) begin
      step(i % 4 == 0, i % 2 == 0, ((i / 4) % 100) < 8, 1'b0, i == rst_at);
    end
  endtask

  task automatic clear_stats();
    sd_peak = 0; rises = 0; tog_flips = 0; last_w = 0;
  endtask

  initial begin : stim
    bit hs_r, vs_r;
    hs_r = 0;
    vs_r = 0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0, 0);
    check("rst_hcnt", 32'(hcnt), 0);
    check("rst_sd_hcnt", 32'(sd_hcnt), 0);
    check("rst_hs_sd", 32'(hs_sd), 0);
    check("rst_model_hsmax", 32'(m_hsmax), 511);

    // Steady lines, measured once the line length has been learned.
    repeat (2) steady(400, -1);
    clear_stats();
    repeat (3) steady(400, -1);
    check("steady_sd_peak", 32'(sd_peak), 99);
    check("steady_pulses", 32'(rises), 6);
    check("steady_toggles", 32'(tog_flips), 3);
    check("steady_width", 32'(last_w), 16);
    check("steady_model_hsmax", 32'(m_hsmax), 99);
    check("steady_model_hslen", 32'(m_hslen), 32);

    // Reset in the middle of the mid-line pulse.
    steady(204, -1);
    check("midpulse_hcnt", 32'(hcnt), 50);
    check("midpulse_hs_sd", 32'(hs_sd), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("reset_hcnt", 32'(hcnt), 0);
    check("reset_sd_hcnt", 32'(sd_hcnt), 0);
    check("reset_toggle", 32'(line_toggle), 0);
    check("reset_hs_sd", 32'(hs_sd), 0);
    check("reset_vs_out", 32'(vs_out), 0);
    check("reset_model_hsmax", 32'(m_hsmax), 511);
    repeat (2) steady(400, -1);
    clear_stats();
    repeat (2) steady(400, -1);
    check("recover_sd_peak", 32'(sd_peak), 99);
    check("recover_pulses", 32'(rises), 4);
    check("recover_width", 32'(last_w), 16);

    // Overlong line: 600 pe_in without hsync.
    for (int i = 0; i < 1200; i++) step(i % 2 == 0, i % 2 == 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("overlong_hcnt", 32'(hcnt), 511);
    step(1, 0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("overlong_model_hsmax", 32'(m_hsmax), 511);
    check("overlong_hcnt_restart", 32'(hcnt), 0);
    clear_stats();
    for (int i = 0; i < 1100; i++) step(i % 4 == 0, i % 2 == 0, 0, 0, 0);
    check("overlong_sd_peak", 32'(sd_peak), 511);

    // Short hsync: one clock high.
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    clear_stats();
    for (int i = 0; i < 1100; i++) step(i % 4 == 0, i % 2 == 0, 0, 0, 0);
    check("short_model_hslen", 32'(m_hslen), 1);
    check("short_width", 32'(last_w), 1);

    // vsync only moves on pe_out.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("vs_hold", 32'(vs_out), 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("vs_update", 32'(vs_out), 1);
    step(0, 0, 0, 0, 0);
    check("vs_hold_high", 32'(vs_out), 1);

    // Random traffic, including coincident strobes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) hs_r = ~hs_r;
      if ($urandom_range(0, 49) == 0) vs_r = ~vs_r;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, hs_r, vs_r,
           $urandom_range(0, 799) == 0);
    end
    step(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
